// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: pulses the PLL reset, supervises lock and releases the system reset
// only after lock has been stable for a programmable time.
module pll_reset_sequencer #(
    parameter int RST_PULSE    = 16,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int LOCK_STABLE  = 1024,
    parameter int RESET_HOLD   = 256,
    parameter int CNT_WIDTH    = 17
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic       relock_ack,
    output logic [2:0] state,
    output logic [3:0] retry_count
);
    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABILIZE = 3'd2,
        S_HOLD      = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] C_PULSE   = CNT_WIDTH'(RST_PULSE - 1);
    localparam logic [CNT_WIDTH-1:0] C_TIMEOUT = CNT_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] C_STABLE  = CNT_WIDTH'(LOCK_STABLE - 1);
    localparam logic [CNT_WIDTH-1:0] C_HOLD    = CNT_WIDTH'(RESET_HOLD - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_ack;
    logic [3:0]             r_retry;
    logic                   w_timeout;
    logic                   w_relock;

    // r_sync2 is the synchronised lock; a lock drop always wins over a finishing count
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        w_relock  = 1'b0;
        case (r_state)
            S_RESET_PLL: if (r_cnt == C_PULSE) w_next = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (r_sync2) begin
                    w_next = S_STABILIZE;
                end else if (r_cnt == C_TIMEOUT) begin
                    w_next    = S_RESET_PLL;
                    w_timeout = 1'b1;
                end
            end
            S_STABILIZE: w_next = !r_sync2 ? S_WAIT_LOCK : (r_cnt == C_STABLE) ? S_HOLD : S_STABILIZE;
            S_HOLD:      w_next = !r_sync2 ? S_WAIT_LOCK : (r_cnt == C_HOLD) ? S_RUN : S_HOLD;
            S_RUN: begin
                if (relock_req) begin
                    w_next   = S_RESET_PLL;
                    w_relock = 1'b1;
                end else if (!r_sync2) begin
                    w_next = S_WAIT_LOCK;
                end
            end
            default: w_next = S_RESET_PLL;
        endcase
    end

    // counter restarts on every state change and idles in RUN, where nothing is timed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= S_RESET_PLL;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_retry <= 4'd0;
        end else begin
            r_sync1 <= pll_locked;
            r_sync2 <= r_sync1;
            r_state <= w_next;
            r_cnt   <= (w_next != r_state || r_state == S_RUN) ? '0 : r_cnt + CNT_WIDTH'(1);
            r_ack   <= w_relock;
            if (w_timeout && r_retry != 4'hF) r_retry <= r_retry + 4'd1;
        end
    end

    assign pll_rst     = (r_state == S_RESET_PLL);
    assign sys_reset   = (r_state != S_RUN);
    assign ready       = (r_state == S_RUN);
    assign relock_ack  = r_ack;
    assign state       = r_state;
    assign retry_count = r_retry;
endmodule
